rtc_access_scheduler: RTL and testbench

Sequences all traffic to the external RTC chip's register bus. Arbitrates between user-programming writes from the button control FSM (address code + BCD byte) and a periodic refresh sweep that reads the nine time/date/timer registers into shadow registers for display. Sits between the user control FSM and the low-level bus driver, which owns pin timing and reports completion with `bus_done`.

---
 rtl/rtc_pkg.sv | 51 +++++
 rtl/rtc_refresh_timer.sv | 25 ++
 rtl/rtc_access_scheduler.sv | 223 ++++++++++++++++++++++
 tb/tb_rtc_access_scheduler.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC register bus: scheduler state encoding,
// register codes 0..8 (also used by the button control FSM) and the
// code-to-chip-address map.
package rtc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    WR_WAIT,
    RD_ISSUE,
    RD_WAIT,
    RD_NEXT
  } rtc_state_t;

  localparam logic [3:0] CODE_HORA  = 4'd0;
  localparam logic [3:0] CODE_MIN   = 4'd1;
  localparam logic [3:0] CODE_SEG   = 4'd2;
  localparam logic [3:0] CODE_DIA   = 4'd3;
  localparam logic [3:0] CODE_MES   = 4'd4;
  localparam logic [3:0] CODE_ANNO  = 4'd5;
  localparam logic [3:0] CODE_THORA = 4'd6;
  localparam logic [3:0] CODE_TMIN  = 4'd7;
  localparam logic [3:0] CODE_TSEG  = 4'd8;
  localparam logic [3:0] CODE_LAST  = CODE_TSEG;

  localparam logic [7:0] ADDR_HORA  = 8'h23;
  localparam logic [7:0] ADDR_MIN   = 8'h22;
  localparam logic [7:0] ADDR_SEG   = 8'h21;
  localparam logic [7:0] ADDR_DIA   = 8'h24;
  localparam logic [7:0] ADDR_MES   = 8'h25;
  localparam logic [7:0] ADDR_ANNO  = 8'h26;
  localparam logic [7:0] ADDR_THORA = 8'h43;
  localparam logic [7:0] ADDR_TMIN  = 8'h42;
  localparam logic [7:0] ADDR_TSEG  = 8'h41;

  function automatic logic [7:0] code_to_addr(input logic [3:0] code);
    case (code)
      CODE_HORA:  code_to_addr = ADDR_HORA;
      CODE_MIN:   code_to_addr = ADDR_MIN;
      CODE_SEG:   code_to_addr = ADDR_SEG;
      CODE_DIA:   code_to_addr = ADDR_DIA;
      CODE_MES:   code_to_addr = ADDR_MES;
      CODE_ANNO:  code_to_addr = ADDR_ANNO;
      CODE_THORA: code_to_addr = ADDR_THORA;
      CODE_TMIN:  code_to_addr = ADDR_TMIN;
      CODE_TSEG:  code_to_addr = ADDR_TSEG;
      default:    code_to_addr = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/rtc_refresh_timer.sv
// Free-running terminal-count counter: counts 0..REFRESH_CYCLES-1 and
// asserts tick during the terminal cycle, then wraps to 0.
module rtc_refresh_timer #(
  parameter int unsigned REFRESH_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_CYCLES - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  // Cycle counter with wrap at terminal count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     count <= '0;
    else if (tick) count <= '0;
    else           count <= count + 1'b1;
  end

endmodule

// File: rtl/rtc_access_scheduler.sv
// Arbiter for the RTC chip register bus: user writes (priority) versus a
// periodic nine-register refresh sweep into shadow registers.
// Optional feature macro: RTC_WATCHDOG_EN (bus wait watchdog, bus_err).
module rtc_access_scheduler #(
  parameter int unsigned REFRESH_CYCLES = 100000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_req,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  output logic       wr_err,
  output logic       bus_start,
  output logic       bus_rw,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  input  logic [7:0] bus_rdata,
  input  logic       bus_done,
  output logic [7:0] hora,
  output logic [7:0] min,
  output logic [7:0] seg,
  output logic [7:0] dia,
  output logic [7:0] mes,
  output logic [7:0] anno,
  output logic [7:0] thora,
  output logic [7:0] tmin,
  output logic [7:0] tseg,
  output logic       rd_valid,
  output logic       busy,
  output logic       bus_err
);
  import rtc_pkg::*;

  rtc_state_t      state, state_n;
  logic [3:0]      idx, idx_n;
  logic [3:0]      wr_addr_q;
  logic [7:0]      wr_data_q;
  logic            refresh_flag, sweep_active, refresh_tick;
  logic            latch_wr, issue_wr, issue_rd, sweep_start, sweep_end, store;
  logic            in_wait, done_ok, timeout, wait_done;
  logic [8:0][7:0] shadow;

  rtc_refresh_timer #(.REFRESH_CYCLES(REFRESH_CYCLES)) u_timer (
    .clk   (clk),
    .reset (reset),
    .tick  (refresh_tick)
  );

  assign in_wait   = (state == WR_WAIT) || (state == RD_WAIT);
  // A done coincident with the launching start pulse belongs to nothing.
  assign done_ok   = bus_done && !bus_start;
  assign wait_done = done_ok || timeout;

`ifdef RTC_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_count;

  // Counts cycles spent waiting for the driver; cleared outside wait states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      wd_count <= '0;
    else if (in_wait && !wait_done) wd_count <= wd_count + 1'b1;
    else                            wd_count <= '0;
  end

  assign timeout = in_wait && (wd_count == WD_W'(TIMEOUT_CYCLES));
`else
  assign timeout = 1'b0;
`endif

  assign bus_err = timeout;

  // State and sweep index register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  // Next-state logic, request acknowledge and per-state control strobes.
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    wr_ack      = 1'b0;
    wr_err      = 1'b0;
    rd_valid    = 1'b0;
    latch_wr    = 1'b0;
    issue_wr    = 1'b0;
    issue_rd    = 1'b0;
    sweep_start = 1'b0;
    sweep_end   = 1'b0;
    store       = 1'b0;
    case (state)
      IDLE: begin
        if (wr_req && !reset) begin
          wr_ack = 1'b1;
          if (wr_addr > CODE_LAST) begin
            wr_err = 1'b1;
          end else begin
            latch_wr = 1'b1;
            state_n  = WR_ISSUE;
          end
        end else if (refresh_flag) begin
          sweep_start = 1'b1;
          idx_n       = '0;
          state_n     = RD_ISSUE;
        end
      end
      WR_ISSUE: begin
        issue_wr = 1'b1;
        state_n  = WR_WAIT;
      end
      WR_WAIT: begin
        if (wait_done) state_n = sweep_active ? RD_ISSUE : IDLE;
      end
      RD_ISSUE: begin
        issue_rd = 1'b1;
        state_n  = RD_WAIT;
      end
      RD_WAIT: begin
        if (wait_done) begin
          store   = done_ok;
          state_n = RD_NEXT;
        end
      end
      RD_NEXT: begin
        if (idx == CODE_LAST) begin
          rd_valid  = 1'b1;
          sweep_end = 1'b1;
          state_n   = IDLE;
        end else begin
          // Index advances now so a write detour resumes at the next register.
          idx_n   = idx + 1'b1;
          state_n = RD_ISSUE;
          if (wr_req) begin
            wr_ack = 1'b1;
            if (wr_addr > CODE_LAST) begin
              wr_err = 1'b1;
            end else begin
              latch_wr = 1'b1;
              state_n  = WR_ISSUE;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Refresh request flag (one-deep, set at reset) and sweep-in-progress flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_flag <= 1'b1;
      sweep_active <= 1'b0;
    end else begin
      if (sweep_end)         refresh_flag <= 1'b0;
      else if (refresh_tick) refresh_flag <= 1'b1;
      if (sweep_end)         sweep_active <= 1'b0;
      else if (sweep_start)  sweep_active <= 1'b1;
    end
  end

  // Latch the accepted user write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (latch_wr) begin
      wr_addr_q <= wr_addr;
      wr_data_q <= wr_data;
    end
  end

  // Registered bus command; fields only change when a new transaction issues.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_start <= 1'b0;
      bus_rw    <= 1'b1;
      bus_addr  <= '0;
      bus_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      bus_start <= issue_wr || issue_rd;
      if (issue_wr) begin
        bus_rw    <= 1'b0;
        bus_addr  <= code_to_addr(wr_addr_q);
        bus_wdata <= wr_data_q;
      end else if (issue_rd) begin
        bus_rw    <= 1'b1;
        bus_addr  <= code_to_addr(idx);
      end
      if (issue_wr || issue_rd)   busy <= 1'b1;
      else if (in_wait && wait_done) busy <= 1'b0;
    end
  end

  // Shadow registers, updated one at a time as reads complete.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow <= '0;
    end else begin
      for (int unsigned i = 0; i < 9; i++) begin
        if (store && (idx == i[3:0])) shadow[i] <= bus_rdata;
      end
    end
  end

  assign hora  = shadow[CODE_HORA];
  assign min   = shadow[CODE_MIN];
  assign seg   = shadow[CODE_SEG];
  assign dia   = shadow[CODE_DIA];
  assign mes   = shadow[CODE_MES];
  assign anno  = shadow[CODE_ANNO];
  assign thora = shadow[CODE_THORA];
  assign tmin  = shadow[CODE_TMIN];
  assign tseg  = shadow[CODE_TSEG];

endmodule

// File: tb/tb_rtc_access_scheduler.sv
// Directed bench for rtc_access_scheduler: reset values, refresh sweep order
// and shadows, a table of user writes, a write interleaved in a sweep, and
// dropped refresh ticks on a short-period instance.
module tb_rtc_access_scheduler;

  typedef struct {
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         cyc;
  } txn_t;

  typedef struct {
    logic [3:0] code;
    logic [7:0] data;
    logic       exp_err;
    logic [7:0] exp_addr;
  } wvec_t;

  logic clk, reset;
  int   cyc = 0;
  int   nvec = 0, nerr = 0;

  // Main instance signals
  logic       wr_req, wr_ack, wr_err;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       bus_start, bus_rw, bus_done, rd_valid, busy, bus_err;
  logic [7:0] bus_addr, bus_wdata, bus_rdata;
  logic [7:0] hora, min, seg, dia, mes, anno, thora, tmin, tseg;
  logic [7:0] sh [9];

  // Short-refresh instance signals
  logic       wr_req2, wr_ack2, wr_err2;
  logic [3:0] wr_addr2;
  logic [7:0] wr_data2;
  logic       bus_start2, bus_rw2, bus_done2, rd_valid2, busy2, bus_err2;
  logic [7:0] bus_addr2, bus_wdata2, bus_rdata2;
  logic [7:0] h2, mi2, s2, d2, me2, a2, th2, tm2, ts2;

  logic [7:0] exp_addr [9] = '{8'h23, 8'h22, 8'h21, 8'h24, 8'h25, 8'h26, 8'h43, 8'h42, 8'h41};

  rtc_access_scheduler #(.REFRESH_CYCLES(5000), .TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .reset(reset), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_err(wr_err), .bus_start(bus_start), .bus_rw(bus_rw),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_done(bus_done),
    .hora(hora), .min(min), .seg(seg), .dia(dia), .mes(mes), .anno(anno),
    .thora(thora), .tmin(tmin), .tseg(tseg), .rd_valid(rd_valid), .busy(busy), .bus_err(bus_err)
  );

  rtc_access_scheduler #(.REFRESH_CYCLES(20), .TIMEOUT_CYCLES(255)) dut2 (
    .clk(clk), .reset(reset), .wr_req(wr_req2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .wr_ack(wr_ack2), .wr_err(wr_err2), .bus_start(bus_start2), .bus_rw(bus_rw2),
    .bus_addr(bus_addr2), .bus_wdata(bus_wdata2), .bus_rdata(bus_rdata2), .bus_done(bus_done2),
    .hora(h2), .min(mi2), .seg(s2), .dia(d2), .mes(me2), .anno(a2),
    .thora(th2), .tmin(tm2), .tseg(ts2), .rd_valid(rd_valid2), .busy(busy2), .bus_err(bus_err2)
  );

  always_comb begin
    sh[0] = hora; sh[1] = min;  sh[2] = seg;
    sh[3] = dia;  sh[4] = mes;  sh[5] = anno;
    sh[6] = thora; sh[7] = tmin; sh[8] = tseg;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] idx_of(input logic [7:0] a);
    idx_of = 8'h00;
    for (int i = 0; i < 9; i++) if (exp_addr[i] == a) idx_of = 8'(i);
  endfunction

  // Bus driver models: bus_done lands drv_delay cycles after bus_start.
  logic       drv_en;
  int         drv_delay;
  logic [7:0] rd_base;
  int         cnt1 = 0, cnt2 = 0;

  initial begin
    bus_done = 1'b0; bus_rdata = 8'h00;
    forever begin
      @(negedge clk);
      bus_done = 1'b0;
      if (cnt1 != 0) begin
        cnt1--;
        if (cnt1 == 0) begin
          bus_done  = 1'b1;
          bus_rdata = rd_base + idx_of(bus_addr);
        end
      end
      if (bus_start && drv_en) cnt1 = drv_delay;
    end
  end

  initial begin
    bus_done2 = 1'b0; bus_rdata2 = 8'h00;
    forever begin
      @(negedge clk);
      bus_done2 = 1'b0;
      if (cnt2 != 0) begin
        cnt2--;
        if (cnt2 == 0) bus_done2 = 1'b1;
      end
      if (bus_start2) cnt2 = 5;
    end
  end

  // Monitors
  txn_t log1[$];
  int   rd_count1 = 0, nberr1 = 0, berr_cyc1 = -1;
  logic prev_done1 = 1'b0;

  initial begin
    forever begin
      @(negedge clk); #1;
      if (!reset) begin
        if (bus_start) begin
          log1.push_back('{rw: bus_rw, addr: bus_addr, wdata: bus_wdata, cyc: cyc});
          check("busy_at_start", 32'(busy), 32'd1);
        end
        if (prev_done1) check("busy_after_done", 32'(busy), 32'd0);
        prev_done1 = bus_done;
        if (rd_valid) rd_count1++;
        if (bus_err) begin nberr1++; berr_cyc1 = cyc; end
      end
    end
  end

  int d2_first_start = -1, d2_nbefore = 0, d2_rdv = -1, d2_next_start = -1;

  initial begin
    forever begin
      @(negedge clk); #1;
      if (!reset) begin
        if (bus_start2) begin
          if (d2_first_start < 0) d2_first_start = cyc;
          if (d2_rdv < 0) d2_nbefore++;
          else if (d2_next_start < 0) d2_next_start = cyc;
        end
        if (rd_valid2 && d2_rdv < 0) d2_rdv = cyc;
      end
    end
  end

  task automatic do_write(input logic [3:0] code, input logic [7:0] data,
                          output logic got, output logic err, output int ack_cyc);
    got = 1'b0; err = 1'b0; ack_cyc = -1;
    wr_req = 1'b1; wr_addr = code; wr_data = data;
    for (int t = 0; t < 300 && !got; t++) begin
      #1;
      if (wr_ack) begin got = 1'b1; err = wr_err; ack_cyc = cyc; end
      @(negedge clk);
    end
    wr_req = 1'b0;
  endtask

  wvec_t wv [8];
  logic  got, err;
  int    ack_cyc, t, rd_before;

  initial begin
    wv[0] = '{code: 4'd5,  data: 8'h16, exp_err: 1'b0, exp_addr: 8'h26};
    wv[1] = '{code: 4'd0,  data: 8'h12, exp_err: 1'b0, exp_addr: 8'h23};
    wv[2] = '{code: 4'd8,  data: 8'h59, exp_err: 1'b0, exp_addr: 8'h41};
    wv[3] = '{code: 4'd12, data: 8'h99, exp_err: 1'b1, exp_addr: 8'h00};
    wv[4] = '{code: 4'd6,  data: 8'h01, exp_err: 1'b0, exp_addr: 8'h43};
    wv[5] = '{code: 4'd9,  data: 8'h00, exp_err: 1'b1, exp_addr: 8'h00};
    wv[6] = '{code: 4'd15, data: 8'h77, exp_err: 1'b1, exp_addr: 8'h00};
    wv[7] = '{code: 4'd2,  data: 8'h45, exp_err: 1'b0, exp_addr: 8'h21};

    reset = 1'b1; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    wr_req2 = 1'b0; wr_addr2 = '0; wr_data2 = '0;
    drv_en = 1'b1; drv_delay = 3; rd_base = 8'h10;
    repeat (3) @(negedge clk);
    #1;
    check("rst_bus_start", 32'(bus_start), 32'd0);
    check("rst_wr_ack",    32'(wr_ack),    32'd0);
    check("rst_wr_err",    32'(wr_err),    32'd0);
    check("rst_rd_valid",  32'(rd_valid),  32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_bus_err",   32'(bus_err),   32'd0);
    check("rst_bus_rw",    32'(bus_rw),    32'd1);
    check("rst_bus_addr",  32'(bus_addr),  32'h00);
    check("rst_bus_wdata", 32'(bus_wdata), 32'h00);
    for (int k = 0; k < 9; k++) check($sformatf("rst_shadow%0d", k), 32'(sh[k]), 32'h00);

    // First sweep starts straight out of reset.
    @(negedge clk);
    reset = 1'b0;
    t = 0;
    while (rd_count1 < 1 && t < 500) begin @(negedge clk); t++; end
    repeat (5) @(negedge clk);
    check("sweep1_rd_valid_count", 32'(rd_count1), 32'd1);
    check("sweep1_reads", 32'(log1.size()), 32'd9);
    for (int k = 0; k < 9 && k < log1.size(); k++) begin
      check($sformatf("sweep1_rw%0d", k),   32'(log1[k].rw),   32'd1);
      check($sformatf("sweep1_addr%0d", k), 32'(log1[k].addr), 32'(exp_addr[k]));
    end
    for (int k = 0; k < 9; k++)
      check($sformatf("sweep1_shadow%0d", k), 32'(sh[k]), 32'(8'h10 + 8'(k)));
    log1.delete();

    // Write table, issued from IDLE.
    for (int v = 0; v < 8; v++) begin
      do_write(wv[v].code, wv[v].data, got, err, ack_cyc);
      check($sformatf("wv%0d_ack", v), 32'(got), 32'd1);
      check($sformatf("wv%0d_err", v), 32'(err), 32'(wv[v].exp_err));
      repeat (10) @(negedge clk);
      if (wv[v].exp_err) begin
        check($sformatf("wv%0d_no_bus", v), 32'(log1.size()), 32'd0);
      end else begin
        check($sformatf("wv%0d_nbus", v), 32'(log1.size()), 32'd1);
        if (log1.size() > 0) begin
          check($sformatf("wv%0d_rw", v),    32'(log1[0].rw),    32'd0);
          check($sformatf("wv%0d_addr", v),  32'(log1[0].addr),  32'(wv[v].exp_addr));
          check($sformatf("wv%0d_wdata", v), 32'(log1[0].wdata), 32'(wv[v].data));
          check($sformatf("wv%0d_latency", v), 32'(log1[0].cyc - ack_cyc), 32'd2);
        end
      end
      log1.delete();
    end

    // Write of code 1 raised during the read of index 3 of the next sweep.
    rd_base = 8'h20;
    rd_before = rd_count1;
    t = 0;
    while (log1.size() < 4 && t < 6000) begin @(negedge clk); t++; end
    check("sweep2_reached_idx3", 32'(log1.size() >= 4), 32'd1);
    do_write(4'd1, 8'h33, got, err, ack_cyc);
    check("mid_ack", 32'(got), 32'd1);
    check("mid_err", 32'(err), 32'd0);
    if (log1.size() >= 4) check("mid_ack_after_idx3", 32'(ack_cyc - log1[3].cyc), 32'd4);
    t = 0;
    while (rd_count1 == rd_before && t < 300) begin @(negedge clk); t++; end
    repeat (5) @(negedge clk);
    check("sweep2_rd_valid_count", 32'(rd_count1 - rd_before), 32'd1);
    check("sweep2_txns", 32'(log1.size()), 32'd10);
    for (int k = 0; k < 10 && k < log1.size(); k++) begin
      if (k == 4) begin
        check("mid_wr_rw",    32'(log1[k].rw),    32'd0);
        check("mid_wr_addr",  32'(log1[k].addr),  32'h22);
        check("mid_wr_wdata", 32'(log1[k].wdata), 32'h33);
        check("mid_wr_latency", 32'(log1[k].cyc - ack_cyc), 32'd2);
      end else begin
        check($sformatf("sweep2_rw%0d", k),   32'(log1[k].rw),   32'd1);
        check($sformatf("sweep2_addr%0d", k), 32'(log1[k].addr), 32'(exp_addr[(k < 4) ? k : k - 1]));
      end
    end
    for (int k = 0; k < 9; k++)
      check($sformatf("sweep2_shadow%0d", k), 32'(sh[k]), 32'(8'h20 + 8'(k)));

    // Short refresh period, sweep (70 cycles) longer than period (20):
    // next sweep waits for the next real tick, 10 cycles after rd_valid.
    check("short_reads_in_sweep", 32'(d2_nbefore), 32'd9);
    check("short_sweep_length",   32'(d2_rdv - d2_first_start), 32'd70);
    check("short_no_dup_sweep",   32'(d2_next_start - d2_rdv), 32'd10);

`ifdef RTC_WATCHDOG_EN
    // Driver silent: first read times out, next index issues, shadow kept.
    log1.delete();
    drv_en = 1'b0;
    t = 0;
    while (log1.size() < 2 && t < 8000) begin @(negedge clk); t++; end
    check("wd_next_issued", 32'(log1.size() >= 2), 32'd1);
    if (log1.size() >= 2) begin
      check("wd_err_timing",  32'(berr_cyc1 - log1[0].cyc), 32'd255);
      check("wd_next_addr",   32'(log1[1].addr), 32'h22);
      check("wd_next_timing", 32'(log1[1].cyc - log1[0].cyc), 32'd258);
    end
    check("wd_err_count",   32'(nberr1), 32'd1);
    check("wd_hora_kept",   32'(hora), 32'h20);
`else
    check("bus_err_never", 32'(nberr1), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
